alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
Shares the single-cycle combinational ALU (3-bit select: 000 add, 001 sub, 010 and, 011 or, 100 unsigned SLT, others produce 0) between two requesters. Requesters are, for example, the address-generation unit and the branch-compare unit. The block arbitrates round-robin, latches operands, drives the ALU for one execute cycle, and captures the result and zero flag. It then presents the captured response on a valid/ready channel tagged with the requester id. It sits between the requesters and one ALU instance in the multicycle datapath.

Parameters:
WIDTH, 32, operand/result width; must match the ALU.
OPW, 3, ALU select width.
MAXOP, 4, highest legal select code; codes above it are flagged as errors.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req0_valid  in  1  requester 0 has an operation.
req0_ready  out  1  requester 0 operation accepted this cycle.
req0_op  in  OPW  requester 0 ALU select.
req0_a  in  WIDTH  requester 0 operand A.
req0_b  in  WIDTH  requester 0 operand B.
req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1.
alu_sl  out  OPW  to ALU select.
alu_a  out  WIDTH  to ALU Ain.
alu_b  out  WIDTH  to ALU Bin.
alu_out  in  WIDTH  from ALU result.
alu_zero  in  1  from ALU Zero.
rsp_valid  out  1  response available.
rsp_ready  in  1  consumer accepts response.
rsp_id  out  1  requester that issued the response.
rsp_data  out  WIDTH  captured ALU result.
rsp_zero  out  1  captured Zero flag.
rsp_err  out  1  op code was greater than MAXOP.
busy  out  1  state is not IDLE.

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - state to IDLE and the rr pointer to 0 (requester 0 favoured);
  - all latches to 0: the op, A and B operands, id, result, zero and err;
  - outputs: rsp_valid=0, busy=0, req0_ready=req1_ready=0, alu_sl/alu_a/alu_b=0.
- Reset mid-operation drops the in-flight operation; no response is produced.
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - grant rule: if only one reqN_valid is high, grant it; if both are high, grant the requester pointed to by rr;
  - reqN_ready is combinational and high only in IDLE, only for the granted requester, in the same cycle;
  - on that clock edge: latch op/a/b, latch id = granted requester, latch err = (op > MAXOP), go to EXEC;
  - if no valid is high, stay in IDLE.
- EXEC:
  - alu_sl/alu_a/alu_b are driven from the latches; in all other states they show the latched values, so the ALU inputs never come directly from the request ports;
  - on the clock edge: capture alu_out into the result latch and alu_zero into the zero latch, go to RESP.
- RESP:
  - rsp_valid=1; rsp_id, rsp_data, rsp_zero and rsp_err come from the latches and stay stable while rsp_ready is low;
  - on an edge with rsp_ready=1: go to IDLE and set rr = ~id, so the other requester wins the next tie;
  - stall in RESP indefinitely while rsp_ready=0; both reqN_ready stay 0.
- Latency:
  - accept at edge k, result captured at edge k+1, rsp_valid high from k+1 to the handshake;
  - minimum 3 cycles per operation (IDLE, EXEC, RESP with rsp_ready already high);
  - no new accept occurs in the cycle of the RESP handshake; the next grant is evaluated in the following IDLE cycle.
- Illegal op (greater than MAXOP):
  - it is still executed; the ALU yields 0, so rsp_data=0 and rsp_zero=1;
  - rsp_err=1 is reported with that response.
- Request protocol:
  - a requester holding valid low-to-high with ready=0 keeps its payload stable; the arbiter does not require this but latches only on grant;
  - the ungranted requester keeps waiting; no starvation, because round-robin guarantees a grant within one foreign operation.
- All arithmetic is performed by the ALU. The block performs no width extension; operands pass through unchanged at WIDTH bits.

Test Plan:
- Reset, then req0 alone: op=000, a=5, b=7, rsp_ready=1 -> req0_ready is high for 1 cycle; rsp_valid 1 edge later with rsp_id=0, rsp_data=12, rsp_zero=0, rsp_err=0.
- Both requesters valid from reset:
  - req0 is sub 9-9, req1 is or 0xF0|0x0F;
  - required: req0 granted first (rsp_data=0, rsp_zero=1), then req1 (rsp_data=0xFF);
  - a third tie is granted to req0 again (alternation).
- SLT boundary:
  - req1 op=100 with a=0xFFFFFFFF, b=1 -> rsp_data=0 (unsigned compare);
  - req1 op=100 with a=1, b=2 -> rsp_data=1.
- Backpressure: hold rsp_ready=0 for 5 cycles while req0 and req1 are valid -> rsp_valid stays 1, data is stable, both readies stay 0, busy=1; after the release the other requester is granted.
- Illegal op: req0 op=111, a=3, b=4 -> rsp_err=1, rsp_data=0, rsp_zero=1.
- Reset mid-operation: assert rst_n=0 in EXEC -> busy=0 and rsp_valid=0 immediately (asynchronously); after release, no stale response appears and rr=0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin share of one combinational ALU
// between two requesters, with a valid/ready response channel.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3,
  parameter int MAXOP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [OPW-1:0]   alu_sl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             rr_q;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             id_q;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;
  logic             err_q;

  logic             any_v;
  logic             gnt_id;
  logic             accept;
  logic             done;
  logic [OPW-1:0]   op_sel;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic             err_sel;

  // Grant: a lone requester wins; a tie goes to the rr pointer.
  always_comb begin
    any_v   = req0_valid | req1_valid;
    gnt_id  = (req0_valid & req1_valid) ? rr_q : req1_valid;
    accept  = rst_n & (state_q == IDLE) & any_v;
    done    = (state_q == RESP) & rsp_ready;
    op_sel  = gnt_id ? req1_op : req0_op;
    a_sel   = gnt_id ? req1_a : req0_a;
    b_sel   = gnt_id ? req1_b : req0_b;
    err_sel = (op_sel > OPW'(MAXOP));
  end

  assign req0_ready = accept & ~gnt_id;
  assign req1_ready = accept & gnt_id;

  // ALU is only ever fed from the operand latches.
  assign alu_sl = op_q;
  assign alu_a  = a_q;
  assign alu_b  = b_q;

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = res_q;
  assign rsp_zero  = zero_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != IDLE);

  // Next-state logic for IDLE -> EXEC -> RESP -> IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_v) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latches, loaded on grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      id_q  <= 1'b0;
      err_q <= 1'b0;
    end else if (accept) begin
      op_q  <= op_sel;
      a_q   <= a_sel;
      b_q   <= b_sel;
      id_q  <= gnt_id;
      err_q <= err_sel;
    end
  end

  // Result capture at the end of the execute cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q  <= '0;
      zero_q <= 1'b0;
    end else if (state_q == EXEC) begin
      res_q  <= alu_out;
      zero_q <= alu_zero;
    end
  end

  // Round-robin pointer: the other requester wins the next tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= 1'b0;
    end else if (done) begin
      rr_q <= ~id_q;
    end
  end

endmodule
